// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant among requesting masters, with ownership
// handed over only at legal points (end of burst, unlocked, HREADY high).
module ahb_arbiter #(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned DEFAULT_MASTER = 0,
    parameter int unsigned MW             = $clog2(NUM_MASTERS)
) (
    input  logic                   clock,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    input  logic [1:0]             HRESP,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MW-1:0]          HMASTER,
    output logic                   HMASTLOCK
);

    localparam logic [1:0] TRANS_NONSEQ = 2'd2;
    localparam logic [1:0] TRANS_SEQ    = 2'd3;

    localparam logic [MW-1:0]          DEF_IDX   = MW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [MW-1:0]          master_q;
    logic                   mastlock_q;
    logic [3:0]             beat_q, beat_d;
    // Index of the most recent grant winner; the round-robin search starts just after it.
    logic [MW-1:0]          rr_q, rr_d;

    logic [MW-1:0]          grant_idx;
    logic [MW-1:0]          winner;
    logic                   rearb_ok;

    assign HGRANT    = grant_q;
    assign HMASTER   = master_q;
    assign HMASTLOCK = mastlock_q;

    // RETRY and SPLIT (HRESP[1] set) force a rearbitration point even inside a locked sequence.
    assign rearb_ok = ((beat_q <= 4'd1) && !HLOCK[master_q] && !mastlock_q) || HRESP[1];

    // Encode the one-hot grant register into the index of the granted master.
    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
                grant_idx = MW'(i);
            end
        end
    end

    // Round-robin search from rr+1 wrapping to rr itself; nobody requesting -> default master.
    always_comb begin
        logic              found;
        int unsigned       idx;
        logic [MW-1:0]     idx_w;
        winner = DEF_IDX;
        found  = 1'b0;
        idx    = 0;
        idx_w  = '0;
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            idx   = (32'(rr_q) + k) % NUM_MASTERS;
            idx_w = MW'(idx);
            if (!found && HBUSREQ[idx_w]) begin
                winner = idx_w;
                found  = 1'b1;
            end
        end
    end

    // Next grant: rearbitrate whenever allowed, independent of HREADY.
    always_comb begin
        grant_d = grant_q;
        rr_d    = rr_q;
        if (rearb_ok) begin
            grant_d = NUM_MASTERS'(1) << winner;
            rr_d    = winner;
        end
    end

    // Remaining-beat counter of the owner's burst; only advances on accepted transfers.
    always_comb begin
        beat_d = beat_q;
        if (HREADY) begin
            if (HRESP != 2'd0) begin
                beat_d = 4'd0;
            end else if (HTRANS == TRANS_NONSEQ) begin
                unique case (HBURST[2:1])
                    2'b00:   beat_d = 4'd0;
                    2'b01:   beat_d = 4'd3;
                    2'b10:   beat_d = 4'd7;
                    default: beat_d = 4'd15;
                endcase
            end else if (HTRANS == TRANS_SEQ && beat_q != 4'd0) begin
                beat_d = beat_q - 4'd1;
            end
        end
    end

    // State update; handover of the address phase waits for HREADY so wait states keep the owner.
    always_ff @(posedge clock) begin
        if (HRESET) begin
            grant_q    <= DEF_GRANT;
            master_q   <= DEF_IDX;
            mastlock_q <= 1'b0;
            beat_q     <= 4'd0;
            rr_q       <= DEF_IDX;
        end else begin
            grant_q <= grant_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
            if (HREADY) begin
                master_q   <= grant_idx;
                mastlock_q <= HLOCK[grant_idx];
            end
        end
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model of the arbitration rules.
module tb_ahb_arbiter;

    localparam int N   = 4;
    localparam int DEF = 0;

    logic         clock = 1'b0;
    logic         HRESET = 1'b1;
    logic [N-1:0] HBUSREQ = '0;
    logic [N-1:0] HLOCK = '0;
    logic [1:0]   HTRANS = 2'd0;
    logic [2:0]   HBURST = 3'd0;
    logic         HREADY = 1'b1;
    logic [1:0]   HRESP = 2'd0;
    logic [N-1:0] HGRANT;
    logic [1:0]   HMASTER;
    logic         HMASTLOCK;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    ahb_arbiter #(
        .NUM_MASTERS   (N),
        .DEFAULT_MASTER(DEF)
    ) dut (
        .clock    (clock),
        .HRESET   (HRESET),
        .HBUSREQ  (HBUSREQ),
        .HLOCK    (HLOCK),
        .HTRANS   (HTRANS),
        .HBURST   (HBURST),
        .HREADY   (HREADY),
        .HRESP    (HRESP),
        .HGRANT   (HGRANT),
        .HMASTER  (HMASTER),
        .HMASTLOCK(HMASTLOCK)
    );

    // ---------------- reference model ----------------
    int m_grant  = DEF;
    int m_master = DEF;
    int m_beats  = 0;   // beats of the current burst still to come
    bit m_lock   = 1'b0;

    function automatic int burst_len(logic [2:0] b);
        case (b)
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            3'd6, 3'd7: return 16;
            default:    return 1;
        endcase
    endfunction

    function automatic int pick(int cur, logic [N-1:0] req);
        int j;
        for (int k = 1; k <= N; k++) begin
            j = (cur + k) % N;
            if (req[j[1:0]]) return j;
        end
        return DEF;
    endfunction

    always @(posedge clock) begin : model
        int nxt;
        bit rearb;
        if (HRESET) begin
            m_grant  = DEF;
            m_master = DEF;
            m_lock   = 1'b0;
            m_beats  = 0;
        end else begin
            rearb = (m_beats <= 1 && !HLOCK[m_master[1:0]] && !m_lock)
                    || HRESP == 2'd2 || HRESP == 2'd3;
            nxt = rearb ? pick(m_grant, HBUSREQ) : m_grant;
            if (HREADY) begin
                m_master = m_grant;
                m_lock   = HLOCK[m_grant[1:0]];
                if (HRESP != 2'd0)                    m_beats = 0;
                else if (HTRANS == 2'd2)              m_beats = burst_len(HBURST) - 1;
                else if (HTRANS == 2'd3 && m_beats > 0) m_beats = m_beats - 1;
            end
            m_grant = nxt;
        end
    end

    // One clock: inputs set at a falling edge are sampled at the rising edge, outputs
    // are observed at the next falling edge.
    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        cyc();
        HRESET = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        HRESET = 1'b1; HBUSREQ = 4'b1111; HLOCK = '0; HTRANS = 2'd0; HBURST = 3'd0;
        HREADY = 1'b1; HRESP = 2'd0;
        repeat (2) cyc();
        checks++;
        if (HGRANT !== 4'b0001) begin
            errors++; $display("FAIL reset_grant: got %b want 0001", HGRANT);
        end
        checks++;
        if (HMASTER !== 2'd0) begin
            errors++; $display("FAIL reset_master: got %0d want 0", HMASTER);
        end
        checks++;
        if (HMASTLOCK !== 1'b0) begin
            errors++; $display("FAIL reset_lock: got %b want 0", HMASTLOCK);
        end
        HRESET = 1'b0; HBUSREQ = 4'b0000;
        cyc();
        checks++;
        if (HGRANT !== 4'b0001) begin
            errors++; $display("FAIL idle_default_grant: got %b want 0001", HGRANT);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] gexp [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100};
        logic [1:0] mexp [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
        do_reset();
        HBUSREQ = 4'b1110; HTRANS = 2'd2; HBURST = 3'd0; HREADY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if (HGRANT !== gexp[i]) begin
                errors++; $display("FAIL rr_grant[%0d]: got %b want %b", i, HGRANT, gexp[i]);
            end
            checks++;
            if (HMASTER !== mexp[i]) begin
                errors++; $display("FAIL rr_master[%0d]: got %0d want %0d", i, HMASTER, mexp[i]);
            end
        end
    endtask

    task automatic test_burst_hold();
        do_reset();
        HBUSREQ = 4'b0010; HTRANS = 2'd0; HREADY = 1'b1;
        repeat (2) cyc();
        checks++;
        if (HMASTER !== 2'd1) begin
            errors++; $display("FAIL burst_setup_master: got %0d want 1", HMASTER);
        end
        HTRANS = 2'd2; HBURST = 3'b011;
        cyc();
        HBUSREQ = 4'b0110; HTRANS = 2'd3;
        repeat (2) begin
            cyc();
            checks++;
            if (HGRANT !== 4'b0010) begin
                errors++; $display("FAIL burst_hold_grant: got %b want 0010", HGRANT);
            end
        end
        cyc();
        checks++;
        if (HGRANT !== 4'b0100 || HMASTER !== 2'd1) begin
            errors++;
            $display("FAIL burst_last_beat: got grant %b master %0d want 0100/1", HGRANT, HMASTER);
        end
        HTRANS = 2'd0;
        cyc();
        checks++;
        if (HMASTER !== 2'd2) begin
            errors++; $display("FAIL burst_handover: got %0d want 2", HMASTER);
        end
    endtask

    task automatic test_wait_states();
        // continues from master 2 owning with no burst pending
        HBUSREQ = 4'b1000; HTRANS = 2'd0; HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (HGRANT !== 4'b1000 || HMASTER !== 2'd2) begin
                errors++;
                $display("FAIL wait_hold[%0d]: got grant %b master %0d want 1000/2",
                         i, HGRANT, HMASTER);
            end
        end
        HREADY = 1'b1;
        cyc();
        checks++;
        if (HMASTER !== 2'd3) begin
            errors++; $display("FAIL wait_release_master: got %0d want 3", HMASTER);
        end
    endtask

    task automatic test_lock();
        do_reset();
        HBUSREQ = 4'b1001; HLOCK = 4'b0001; HTRANS = 2'd2; HBURST = 3'd0; HREADY = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++;
            if (HGRANT !== 4'b0001 || HMASTLOCK !== 1'b1) begin
                errors++;
                $display("FAIL lock_hold[%0d]: got grant %b lock %b want 0001/1",
                         i, HGRANT, HMASTLOCK);
            end
        end
        HLOCK = 4'b0000;
        cyc();
        checks++;
        if (HGRANT !== 4'b0001 || HMASTLOCK !== 1'b0) begin
            errors++;
            $display("FAIL unlock_edge: got grant %b lock %b want 0001/0", HGRANT, HMASTLOCK);
        end
        cyc();
        checks++;
        if (HGRANT !== 4'b1000) begin
            errors++; $display("FAIL unlock_regrant: got %b want 1000", HGRANT);
        end
    endtask

    task automatic test_retry();
        do_reset();
        HBUSREQ = 4'b0010; HLOCK = '0; HTRANS = 2'd0; HREADY = 1'b1; HRESP = 2'd0;
        repeat (2) cyc();
        HTRANS = 2'd2; HBURST = 3'b101;
        cyc();
        HBUSREQ = 4'b0110; HTRANS = 2'd3;
        repeat (2) cyc();
        checks++;
        if (HGRANT !== 4'b0010) begin
            errors++; $display("FAIL retry_pre_grant: got %b want 0010", HGRANT);
        end
        HRESP = 2'd2;
        cyc();
        checks++;
        if (HGRANT !== 4'b0100) begin
            errors++; $display("FAIL retry_regrant: got %b want 0100", HGRANT);
        end
        HRESP = 2'd0; HTRANS = 2'd0;
        cyc();
        checks++;
        if (HMASTER !== 2'd2) begin
            errors++; $display("FAIL retry_handover: got %0d want 2", HMASTER);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        HBUSREQ = 4'b0010; HLOCK = '0; HTRANS = 2'd0; HREADY = 1'b1; HRESP = 2'd0;
        repeat (2) cyc();
        HLOCK = 4'b0010; HTRANS = 2'd2; HBURST = 3'b111;
        cyc();
        HTRANS = 2'd3; HBUSREQ = 4'b1111;
        cyc();
        checks++;
        if (HMASTLOCK !== 1'b1 || HGRANT !== 4'b0010) begin
            errors++;
            $display("FAIL midburst_setup: got lock %b grant %b want 1/0010", HMASTLOCK, HGRANT);
        end
        HRESET = 1'b1;
        cyc();
        checks++;
        if (HGRANT !== 4'b0001 || HMASTER !== 2'd0 || HMASTLOCK !== 1'b0) begin
            errors++;
            $display("FAIL midburst_reset: got grant %b master %0d lock %b want 0001/0/0",
                     HGRANT, HMASTER, HMASTLOCK);
        end
        HRESET = 1'b0; HLOCK = '0; HBUSREQ = 4'b0100; HTRANS = 2'd0;
        cyc();
        checks++;
        if (HGRANT !== 4'b0100) begin
            errors++; $display("FAIL midburst_counter_cleared: got %b want 0100", HGRANT);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            HRESET  = ($urandom_range(0, 63) == 0);
            HBUSREQ = 4'($urandom);
            HLOCK   = 4'($urandom) & 4'($urandom) & 4'($urandom);
            HTRANS  = 2'($urandom);
            HBURST  = 3'($urandom);
            HREADY  = ($urandom_range(0, 3) != 0);
            HRESP   = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'd0;
            cyc();
            checks++;
            if (HGRANT !== 4'(1 << m_grant) || !$onehot(HGRANT)) begin
                errors++;
                $display("FAIL rand_grant[%0d]: got %b want %b", i, HGRANT, 4'(1 << m_grant));
            end
            checks++;
            if (HMASTER !== 2'(m_master)) begin
                errors++; $display("FAIL rand_master[%0d]: got %0d want %0d", i, HMASTER, m_master);
            end
            checks++;
            if (HMASTLOCK !== m_lock) begin
                errors++; $display("FAIL rand_lock[%0d]: got %b want %b", i, HMASTLOCK, m_lock);
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst_hold();
        test_wait_states();
        test_lock();
        test_retry();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
